// File: rtl/sudoku_pkg.sv
// Shared types, sizes and cursor helpers for the Sudoku game controller.
package sudoku_pkg;

    localparam int N        = 9;
    localparam int CELL_W   = 4;
    localparam int SCAN_LEN = N * N;

    typedef logic [CELL_W-1:0] cell_t;
    typedef cell_t [N-1:0][N-1:0] grid_t;

    typedef enum logic [3:0] {
        KEY_UP    = 4'd1,
        KEY_DOWN  = 4'd2,
        KEY_LEFT  = 4'd3,
        KEY_RIGHT = 4'd4,
        KEY_ENTER = 4'd5,
        KEY_CLEAR = 4'd6,
        KEY_CHECK = 4'd7,
        KEY_NEW   = 4'd8
    } key_cmd_e;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        PLAY,
        CHECK,
        WIN
    } ctrl_state_e;

    function automatic logic [3:0] wrap_inc(input logic [3:0] v);
        return (v == 4'(N - 1)) ? 4'd0 : v + 4'd1;
    endfunction

    function automatic logic [3:0] wrap_dec(input logic [3:0] v);
        return (v == 4'd0) ? 4'(N - 1) : v - 4'd1;
    endfunction

endpackage

// File: rtl/sudoku_grid_scanner.sv
// Row-major 0..SCAN_LEN-1 cell walker shared by the LOAD and CHECK passes.
module sudoku_grid_scanner
    import sudoku_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       start,
    output logic [3:0] row,
    output logic [3:0] col,
    output logic       first,
    output logic       last,
    output logic       done
);

    logic       active;
    logic [6:0] idx;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            active <= 1'b0;
            idx    <= '0;
            row    <= '0;
            col    <= '0;
        end else if (start) begin
            active <= 1'b1;
            idx    <= '0;
            row    <= '0;
            col    <= '0;
        end else if (active) begin
            if (last) begin
                active <= 1'b0;
                idx    <= '0;
                row    <= '0;
                col    <= '0;
            end else begin
                idx <= idx + 7'd1;
                if (col == 4'(N - 1)) begin
                    col <= '0;
                    row <= row + 4'd1;
                end else begin
                    col <= col + 4'd1;
                end
            end
        end
    end

    assign first = (idx == 7'd0);
    assign last  = (idx == 7'(SCAN_LEN - 1));
    // done marks the edge on which the final cell is consumed
    assign done  = active && last;

endmodule

// File: rtl/sudoku_game_ctrl.sv
// Sudoku game sequencer: loads the puzzle, applies keypad edits, scores the grid.
//   state | meaning
//   IDLE  | board blank, waiting for new game
//   LOAD  | copying givens into guess_grid, one cell per cycle
//   PLAY  | cursor moves and cell edits
//   CHECK | counting cells that differ from the solution
//   WIN   | grid matches solution, only new game accepted
module sudoku_game_ctrl
    import sudoku_pkg::*;
(
    input  logic                                   clock,
    input  logic                                   reset,
    input  logic                                   key_valid,
    input  logic [3:0]                             key_input,
    input  logic [3:0]                             user_value,
    input  logic [N-1:0][N-1:0][CELL_W-1:0]        initial_grid,
    input  logic [N-1:0][N-1:0][CELL_W-1:0]        solution_grid,
    output logic [N-1:0][N-1:0][CELL_W-1:0]        guess_grid,
    output logic [3:0]                             cursor_row,
    output logic [3:0]                             cursor_col,
    output logic                                   board_enable,
    output logic                                   board_sel,
    output logic                                   busy,
    output logic                                   solved,
    output logic [6:0]                             mismatch_count
);

    ctrl_state_e state, next_state;

    logic       scan_start, scan_first, scan_last, scan_done;
    logic [3:0] scan_row, scan_col;
    logic [6:0] acc, acc_sum;
    logic       cell_miss, cur_fixed, value_ok, play_key;

    sudoku_grid_scanner u_scanner (
        .clock (clock),
        .reset (reset),
        .start (scan_start),
        .row   (scan_row),
        .col   (scan_col),
        .first (scan_first),
        .last  (scan_last),
        .done  (scan_done)
    );

    assign cell_miss = guess_grid[scan_row][scan_col] != solution_grid[scan_row][scan_col];
    assign acc_sum   = (scan_first ? 7'd0 : acc) + {6'd0, cell_miss};
    assign cur_fixed = initial_grid[cursor_row][cursor_col] != '0;
    assign value_ok  = (user_value >= 4'd1) && (user_value <= 4'(N));
    assign play_key  = (state == PLAY) && key_valid;

    always_comb begin
        next_state = state;
        scan_start = 1'b0;
        case (state)
            IDLE: begin
                if (key_valid && key_input == KEY_NEW) begin
                    next_state = LOAD;
                    scan_start = 1'b1;
                end
            end
            LOAD: begin
                if (scan_done) next_state = PLAY;
            end
            PLAY: begin
                if (key_valid && key_input == KEY_CHECK) begin
                    next_state = CHECK;
                    scan_start = 1'b1;
                end else if (key_valid && key_input == KEY_NEW) begin
                    next_state = LOAD;
                    scan_start = 1'b1;
                end
            end
            CHECK: begin
                if (scan_done) next_state = (acc_sum == 7'd0) ? WIN : PLAY;
            end
            WIN: begin
                if (key_valid && key_input == KEY_NEW) begin
                    next_state = LOAD;
                    scan_start = 1'b1;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state          <= IDLE;
            guess_grid     <= '0;
            cursor_row     <= '0;
            cursor_col     <= '0;
            board_enable   <= 1'b0;
            board_sel      <= 1'b0;
            busy           <= 1'b0;
            solved         <= 1'b0;
            mismatch_count <= '0;
            acc            <= '0;
        end else begin
            state        <= next_state;
            busy         <= (next_state == LOAD) || (next_state == CHECK);
            board_enable <= (next_state == PLAY) || (next_state == CHECK) || (next_state == WIN);
            board_sel    <= (next_state == PLAY) || (next_state == CHECK) || (next_state == WIN);
            solved       <= (next_state == WIN);

            if (state == LOAD) begin
                guess_grid[scan_row][scan_col] <= initial_grid[scan_row][scan_col];
                cursor_row <= '0;
                cursor_col <= '0;
            end

            if (state == CHECK) begin
                acc <= acc_sum;
                if (scan_last) mismatch_count <= acc_sum;
            end

            if (play_key) begin
                case (key_input)
                    KEY_UP:    cursor_row <= wrap_dec(cursor_row);
                    KEY_DOWN:  cursor_row <= wrap_inc(cursor_row);
                    KEY_LEFT:  cursor_col <= wrap_dec(cursor_col);
                    KEY_RIGHT: cursor_col <= wrap_inc(cursor_col);
                    KEY_ENTER: begin
                        if (!cur_fixed && value_ok)
                            guess_grid[cursor_row][cursor_col] <= user_value;
                    end
                    KEY_CLEAR: begin
                        if (!cur_fixed) guess_grid[cursor_row][cursor_col] <= '0;
                    end
                    KEY_CHECK: acc <= '0;
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sudoku_game_ctrl.sv
// Directed bench for sudoku_game_ctrl: load, cursor wrap, edits, check, win, reset abort.
module tb_sudoku_game_ctrl;
    import sudoku_pkg::*;

    logic                           clock = 1'b0;
    logic                           reset;
    logic                           key_valid;
    logic [3:0]                     key_input;
    logic [3:0]                     user_value;
    logic [8:0][8:0][3:0]           initial_grid, solution_grid, guess_grid, exp_g;
    logic [3:0]                     cursor_row, cursor_col;
    logic                           board_enable, board_sel, busy, solved;
    logic [6:0]                     mismatch_count;

    int vectors = 0;
    int miscompares = 0;
    int cnt;

    sudoku_game_ctrl dut (
        .clock          (clock),
        .reset          (reset),
        .key_valid      (key_valid),
        .key_input      (key_input),
        .user_value     (user_value),
        .initial_grid   (initial_grid),
        .solution_grid  (solution_grid),
        .guess_grid     (guess_grid),
        .cursor_row     (cursor_row),
        .cursor_col     (cursor_col),
        .board_enable   (board_enable),
        .board_sel      (board_sel),
        .busy           (busy),
        .solved         (solved),
        .mismatch_count (mismatch_count)
    );

    always #5 clock = ~clock;

    // valid Sudoku: shifted base pattern, digit at (0,0) is 5
    function automatic logic [3:0] sol(input int r, input int c);
        return 4'(((r * 3 + r / 3 + c + 4) % 9) + 1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_grid(input string tag, input logic [323:0] obs, input logic [323:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] k, input logic [3:0] v);
        key_input  = k;
        user_value = v;
        key_valid  = 1'b1;
        @(posedge clock);
        #1;
        key_valid  = 1'b0;
    endtask

    task automatic move(input logic [3:0] k, input int n);
        for (int i = 0; i < n; i++) press(k, 4'd0);
    endtask

    // counts cycles with busy high; optionally injects a key mid-scan
    task automatic scan_wait(output int n, input int inject_at, input logic [3:0] inject_key);
        n = 0;
        while (busy === 1'b1 && n < 200) begin
            n++;
            if (n == inject_at) begin
                key_input = inject_key;
                key_valid = 1'b1;
            end
            @(posedge clock);
            #1;
            key_valid = 1'b0;
        end
    endtask

    initial begin
        reset      = 1'b0;
        key_valid  = 1'b0;
        key_input  = 4'd0;
        user_value = 4'd0;
        for (int r = 0; r < 9; r++)
            for (int c = 0; c < 9; c++) begin
                solution_grid[r][c] = sol(r, c);
                initial_grid[r][c]  = sol(r, c);
            end
        initial_grid[0][1] = 4'd0;
        initial_grid[4][4] = 4'd0;
        initial_grid[8][8] = 4'd0;

        #2 reset = 1'b1;
        #10;
        chk("rst_busy", busy, 0);
        chk("rst_board_enable", board_enable, 0);
        chk("rst_board_sel", board_sel, 0);
        chk("rst_solved", solved, 0);
        chk("rst_mismatch", mismatch_count, 0);
        chk("rst_cursor_row", cursor_row, 0);
        chk("rst_cursor_col", cursor_col, 0);
        chk_grid("rst_grid", guess_grid, '0);

        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;

        press(4'd1, 4'd0);
        chk("idle_ignore_enable", board_enable, 0);
        chk("idle_ignore_busy", busy, 0);

        press(4'd8, 4'd0);
        chk("load_busy_now", busy, 1);
        scan_wait(cnt, 0, 4'd0);
        chk("load_busy_cycles", cnt, 81);
        exp_g = initial_grid;
        chk_grid("load_grid", guess_grid, exp_g);
        chk("play_board_enable", board_enable, 1);
        chk("play_board_sel", board_sel, 1);
        chk("play_cursor_row", cursor_row, 0);
        chk("play_cursor_col", cursor_col, 0);

        press(4'd1, 4'd0);
        chk("wrap_up_row", cursor_row, 8);
        chk("wrap_up_col", cursor_col, 0);
        press(4'd3, 4'd0);
        chk("wrap_left_col", cursor_col, 8);
        chk("wrap_left_row", cursor_row, 8);
        press(4'd2, 4'd0);
        press(4'd4, 4'd0);
        chk("wrap_down_row", cursor_row, 0);
        chk("wrap_right_col", cursor_col, 0);

        press(4'd5, 4'd7);
        chk("fixed_cell_enter", guess_grid[0][0], 5);
        press(4'd6, 4'd0);
        chk("fixed_cell_clear", guess_grid[0][0], 5);

        press(4'd4, 4'd0);
        press(4'd5, 4'd3);
        chk("enter_3", guess_grid[0][1], 3);
        press(4'd6, 4'd0);
        chk("clear_cell", guess_grid[0][1], 0);
        press(4'd5, 4'd0);
        chk("enter_0_ignored", guess_grid[0][1], 0);
        press(4'd5, 4'd10);
        chk("enter_10_ignored", guess_grid[0][1], 0);
        press(4'd9, 4'd4);
        chk("undef_key_row", cursor_row, 0);
        chk("undef_key_col", cursor_col, 1);
        chk_grid("undef_key_grid", guess_grid, exp_g);

        press(4'd5, 4'd6);
        exp_g[0][1] = 4'd6;
        chk_grid("enter_6_grid", guess_grid, exp_g);

        press(4'd7, 4'd0);
        chk("check_busy_now", busy, 1);
        scan_wait(cnt, 10, 4'd2);
        chk("check_busy_cycles", cnt, 81);
        chk("check_mismatch_2", mismatch_count, 2);
        chk("check_not_solved", solved, 0);
        chk("check_enable_kept", board_enable, 1);
        chk("check_key_ignored_row", cursor_row, 0);

        move(4'd2, 4);
        move(4'd4, 3);
        press(4'd5, 4'd4);
        exp_g[4][4] = 4'd4;
        move(4'd2, 4);
        move(4'd4, 4);
        press(4'd5, 4'd3);
        exp_g[8][8] = 4'd3;
        chk_grid("solved_grid", guess_grid, solution_grid);

        press(4'd7, 4'd0);
        scan_wait(cnt, 0, 4'd0);
        chk("check2_busy_cycles", cnt, 81);
        chk("check2_mismatch_0", mismatch_count, 0);
        chk("win_solved", solved, 1);
        chk("win_board_enable", board_enable, 1);
        chk("win_board_sel", board_sel, 1);

        press(4'd1, 4'd0);
        chk("win_key_ignored_row", cursor_row, 8);
        chk("win_key_ignored_solved", solved, 1);

        press(4'd8, 4'd0);
        chk("new_game_solved_drop", solved, 0);
        chk("new_game_busy", busy, 1);

        repeat (40) begin
            @(posedge clock); #1;
        end
        chk("abort_busy_before", busy, 1);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", busy, 0);
        chk("abort_board_enable", board_enable, 0);
        chk("abort_board_sel", board_sel, 0);
        chk("abort_solved", solved, 0);
        chk("abort_mismatch", mismatch_count, 0);
        chk("abort_cursor_row", cursor_row, 0);
        chk("abort_cursor_col", cursor_col, 0);
        chk_grid("abort_grid", guess_grid, '0);

        @(posedge clock); #1;
        reset = 1'b0;
        press(4'd4, 4'd0);
        chk("post_reset_idle_col", cursor_col, 0);
        chk("post_reset_idle_enable", board_enable, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/sudoku_game_ctrl.md
Name: sudoku_game_ctrl

Overview:
- Game-sequencing controller for the Sudoku player.
- Owns the guess grid, the cursor, and the load/play/check/win flow.
- Drives board_enable/board_sel and guess_grid into gamelogic_top; decoded keypad codes and user_value arrive from the input front end.
- Sits between keypad decode and gamelogic_top/display.

Parameters:
- N, 9: grid dimension (rows = cols = N).
- CELL_W, 4: bits per cell value; 0 = empty.
- SCAN_LEN, N*N (81): cells visited per LOAD/CHECK scan.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-high; clears all state.
- key_valid  in  1  one-cycle strobe qualifying key_input.
- key_input  in  4  command code: 1 up, 2 down, 3 left, 4 right, 5 enter, 6 clear, 7 check, 8 new game; others ignored.
- user_value  in  4  digit to write on enter; valid 1..9.
- initial_grid  in  [N][N]x4  puzzle givens; nonzero = fixed cell.
- solution_grid  in  [N][N]x4  reference solution.
- guess_grid  out  [N][N]x4  registered player grid.
- cursor_row  out  4  0..8.
- cursor_col  out  4  0..8.
- board_enable  out  1  display grid valid.
- board_sel  out  1  1 = show guess_grid, 0 = show initial_grid.
- busy  out  1  high in LOAD or CHECK.
- solved  out  1  high in WIN.
- mismatch_count  out  7  result of last CHECK, 0..81.

Behaviour:
- Reset values:
  - state IDLE; guess_grid all 0; cursor (0,0).
  - board_enable 0, board_sel 0, busy 0, solved 0, mismatch_count 0.
  - Scan counter 0.
- Reset mid-LOAD/CHECK aborts immediately to the reset values.
- IDLE: board_enable 0. Key 8 with key_valid -> LOAD. All other keys ignored.
- LOAD:
  - One cell per cycle, row-major; scan counter 0..80 maps to (idx/9, idx%9).
  - guess_grid[r][c] <= initial_grid[r][c]; cursor reset to (0,0).
  - Completes in exactly 81 cycles, then -> PLAY.
  - busy = 1; board_enable 0; keys ignored.
- PLAY:
  - board_enable 1, board_sel 1. Acts on one key per key_valid cycle.
  - 1/2 decrement/increment cursor_row; 3/4 decrement/increment cursor_col.
  - Cursor wraps: 0 - 1 -> 8, 8 + 1 -> 0. The other axis is unchanged.
  - 5: if initial_grid at cursor == 0 and user_value in 1..9, write user_value to guess_grid at cursor next edge. Else no change.
  - 6: if cell not fixed, write 0. Else no change.
  - 7: clear the mismatch accumulator -> CHECK.
  - 8: -> LOAD (restart).
- CHECK:
  - Row-major scan, one cell per cycle, 81 cycles.
  - Accumulator += 1 when guess_grid[r][c] != solution_grid[r][c].
  - Empty cells count as mismatches.
  - At scan end: mismatch_count <= accumulator. -> WIN if 0, else -> PLAY.
  - busy = 1; board_enable stays 1; keys ignored, not queued.
- WIN:
  - solved 1, board_enable 1, board_sel 1.
  - Only key 8 is accepted -> LOAD, and solved drops the same edge.
- key_valid with an undefined code: no state or output change.
- mismatch_count holds its value until the next CHECK completes, or reset.
- All outputs are registered; the effect of a key is visible one cycle after its key_valid edge.

Decomposition:
- sudoku_pkg holds:
  - localparams N, CELL_W, SCAN_LEN.
  - typedef cell_t (logic [3:0]) and grid_t (cell_t [8:0][8:0]).
  - enum key_cmd_e with the codes above.
  - enum ctrl_state_e: IDLE, LOAD, PLAY, CHECK, WIN.
- One sub-module: sudoku_grid_scanner. A 0..80 counter producing row/col indices, first and last flags, and start/done handshakes. It is shared by LOAD and CHECK.

Test Plan:
- Reset, then key 8:
  - busy = 1 for exactly 81 cycles; guess_grid equals initial_grid.
  - State PLAY with board_enable = 1, board_sel = 1, cursor (0,0).
- Cursor wrap:
  - At (0,0), key 1 -> row 8; key 3 -> col 8.
  - At (8,8), key 2 then key 4 -> (0,0).
- Fixed cell: cell (0,0) given as 5; key 5 with user_value 7 -> guess_grid[0][0] stays 5.
- Writable cell: cell (0,1) = 0; key 5 with user_value 3 -> 3. Key 6 -> 0. Key 5 with user_value 0 or 10 -> unchanged.
- Mismatch check:
  - Grid differs from the solution in 2 cells; key 7 -> busy for 81 cycles, mismatch_count = 2, back in PLAY.
  - Key input during the scan is ignored.
- Solve and reset:
  - Fully correct grid; key 7 -> mismatch_count = 0, solved = 1.
  - Key 8 -> solved = 0, LOAD restarts.
  - Assert reset at scan cycle 40 -> all outputs immediately return to their reset values.
